// File: rtl/conv_mac_stage.sv
// conv_mac_stage: three-stage multiply-accumulate for one KERNEL_SIZE x KERNEL_SIZE
// window per cycle. Weights and bias are loaded serially through w_data. Each
// accepted window produces one saturated OUT_W result three cycles later.
module conv_mac_stage #(
  parameter int KERNEL_SIZE = 5,
  parameter int PIX_W       = 8,
  parameter int WGT_W       = 8,
  parameter int BIAS_W      = 16,
  parameter int OUT_W       = 16,
  localparam int N          = KERNEL_SIZE * KERNEL_SIZE,
  localparam int DW         = (WGT_W > BIAS_W) ? WGT_W : BIAS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_load,
  input  logic [DW-1:0]      w_data,
  input  logic               i_valid,
  input  logic [N*PIX_W-1:0] i_window,
  output logic               o_valid,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_sat,
  output logic               o_ready,
  output logic               o_drop
);

  localparam int ACC_W = 32;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

  // Clip a 32-bit total into OUT_W; the MSB of the result flags clipping.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] total);
    logic [OUT_W:0] res;
    if (total > SAT_MAX) begin
      res = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (total < SAT_MIN) begin
      res = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, total[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    wr_weight_s;
  logic                    wr_bias_s;
  logic [CNT_W-1:0]        wr_idx_s;
  logic signed [WGT_W-1:0] weight_r [N];
  logic signed [BIAS_W-1:0] bias_r;
  logic                    accept_s;

  logic signed [ACC_W-1:0] prod_s [N];
  logic signed [ACC_W-1:0] prod_r [N];
  logic signed [BIAS_W-1:0] bias_s1_r;
  logic                    v1_r;
  logic signed [ACC_W-1:0] row_sum_s [KERNEL_SIZE];
  logic signed [ACC_W-1:0] row_r [KERNEL_SIZE];
  logic signed [BIAS_W-1:0] bias_s2_r;
  logic                    v2_r;
  logic signed [ACC_W-1:0] total_s;
  logic [OUT_W:0]          sat_res_s;

  logic                    o_valid_r;
  logic [OUT_W-1:0]        o_data_r;
  logic                    o_sat_r;
  logic                    o_ready_r;
  logic                    o_drop_r;

  // Window is taken only while the weight set is complete; a restart beat on the
  // same edge still sees the old weights because they are overwritten at that edge.
  assign accept_s = i_valid && (state_r == ST_READY);

  // Load FSM next state and the write decode for the current beat.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wr_weight_s = 1'b0;
    wr_bias_s   = 1'b0;
    wr_idx_s    = {CNT_W{1'b0}};
    case (state_r)
      ST_EMPTY, ST_READY: begin
        if (w_load) begin
          wr_weight_s = 1'b1;
          wr_idx_s    = {CNT_W{1'b0}};
          cnt_nxt_s   = CNT_W'(1);
          state_nxt_s = ST_LOADING;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOADING: begin
        if (w_load) begin
          if (cnt_r == CNT_W'(N)) begin
            wr_bias_s   = 1'b1;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_READY;
          end else begin
            wr_weight_s = 1'b1;
            wr_idx_s    = cnt_r;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = ST_LOADING;
        end
      end
      default: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Load FSM state, beat counter and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_EMPTY;
      cnt_r     <= {CNT_W{1'b0}};
      o_ready_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      o_ready_r <= (state_nxt_s == ST_READY);
    end
  end

  // Weight and bias storage written one beat at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        weight_r[i] <= {WGT_W{1'b0}};
      end
      bias_r <= {BIAS_W{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_weight_s && (wr_idx_s == CNT_W'(i))) begin
          weight_r[i] <= w_data[WGT_W-1:0];
        end
      end
      if (wr_bias_s) begin
        bias_r <= w_data[BIAS_W-1:0];
      end
    end
  end

  // Per-element products: pixel is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      prod_s[n] = $signed({{(ACC_W-PIX_W){1'b0}}, i_window[n*PIX_W +: PIX_W]})
                * $signed({{(ACC_W-WGT_W){weight_r[n][WGT_W-1]}}, weight_r[n]});
    end
  end

  // Stage 1: capture products and the bias that belongs to this window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        prod_r[n] <= {ACC_W{1'b0}};
      end
      bias_s1_r <= {BIAS_W{1'b0}};
      v1_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        prod_r    <= prod_s;
        bias_s1_r <= bias_r;
      end
      v1_r <= accept_s;
    end
  end

  // Row sums of the captured products.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc = {ACC_W{1'b0}};
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      acc = {ACC_W{1'b0}};
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        acc = acc + prod_r[r*KERNEL_SIZE + c];
      end
      row_sum_s[r] = acc;
    end
  end

  // Stage 2: capture row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        row_r[r] <= {ACC_W{1'b0}};
      end
      bias_s2_r <= {BIAS_W{1'b0}};
      v2_r      <= 1'b0;
    end else begin
      if (v1_r) begin
        row_r     <= row_sum_s;
        bias_s2_r <= bias_s1_r;
      end
      v2_r <= v1_r;
    end
  end

  // Final total: rows plus sign-extended bias, then clip to the output range.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc = {{(ACC_W-BIAS_W){bias_s2_r[BIAS_W-1]}}, bias_s2_r};
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      acc = acc + row_r[r];
    end
    total_s   = acc;
    sat_res_s = saturate(total_s);
  end

  // Stage 3: registered outputs; data and sat hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_r <= 1'b0;
      o_data_r  <= {OUT_W{1'b0}};
      o_sat_r   <= 1'b0;
      o_drop_r  <= 1'b0;
    end else begin
      if (v2_r) begin
        o_data_r <= sat_res_s[OUT_W-1:0];
        o_sat_r  <= sat_res_s[OUT_W];
      end
      o_valid_r <= v2_r;
      o_drop_r  <= i_valid && (state_r != ST_READY);
    end
  end

  assign o_valid = o_valid_r;
  assign o_data  = o_data_r;
  assign o_sat   = o_sat_r;
  assign o_ready = o_ready_r;
  assign o_drop  = o_drop_r;

endmodule

// File: tb/tb_conv_mac_stage.sv
// Randomized self-checking bench for conv_mac_stage with a behavioural model.
module tb_conv_mac_stage;

  localparam int KS    = 5;
  localparam int N     = KS * KS;
  localparam int PIX_W = 8;
  localparam int WGT_W = 8;
  localparam int OUT_W = 16;
  localparam int DW    = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               w_load;
  logic [DW-1:0]      w_data;
  logic               i_valid;
  logic [N*PIX_W-1:0] i_window;
  logic               o_valid;
  logic [OUT_W-1:0]   o_data;
  logic               o_sat;
  logic               o_ready;
  logic               o_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  logic [7:0]  tb_w [N];
  logic [15:0] tb_bias;

  conv_mac_stage dut (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
    .i_valid(i_valid), .i_window(i_window), .o_valid(o_valid),
    .o_data(o_data), .o_sat(o_sat), .o_ready(o_ready), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           m_w [N];
  int           m_bias;
  logic         m_ready;
  int           m_beat;
  int           cyc;
  logic         slot_v [4];
  logic [15:0]  slot_d [4];
  logic         slot_s [4];
  logic         exp_valid, exp_sat, exp_ready, exp_drop;
  logic [15:0]  exp_data;

  function automatic logic [OUT_W:0] model_result(input logic [N*PIX_W-1:0] win);
    longint acc;
    acc = longint'(m_bias);
    for (int n = 0; n < N; n++) acc += longint'(win[n*PIX_W +: PIX_W]) * longint'(m_w[n]);
    if (acc > 32767) return {1'b1, 16'h7FFF};
    if (acc < -32768) return {1'b1, 16'h8000};
    return {1'b0, acc[15:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_w[i] <= 0;
      for (int i = 0; i < 4; i++) begin
        slot_v[i] <= 1'b0; slot_d[i] <= 16'h0; slot_s[i] <= 1'b0;
      end
      m_bias <= 0; m_ready <= 1'b0; m_beat <= 0; cyc <= 0;
      exp_valid <= 1'b0; exp_sat <= 1'b0; exp_ready <= 1'b0; exp_drop <= 1'b0;
      exp_data <= 16'h0;
    end else begin
      cyc <= cyc + 1;
      exp_valid <= slot_v[cyc % 4];
      if (slot_v[cyc % 4]) begin
        exp_data <= slot_d[cyc % 4];
        exp_sat  <= slot_s[cyc % 4];
      end
      slot_v[cyc % 4] <= 1'b0;
      exp_drop <= i_valid && !m_ready;
      if (i_valid && m_ready) begin
        slot_v[(cyc + 2) % 4] <= 1'b1;
        {slot_s[(cyc + 2) % 4], slot_d[(cyc + 2) % 4]} <= model_result(i_window);
      end
      if (w_load) begin
        if ((m_ready ? 0 : m_beat) == N) begin
          m_bias  <= int'($signed(w_data[15:0]));
          m_ready <= 1'b1;
          m_beat  <= 0;
        end else begin
          m_w[m_ready ? 0 : m_beat] <= int'($signed(w_data[WGT_W-1:0]));
          m_ready <= 1'b0;
          m_beat  <= (m_ready ? 0 : m_beat) + 1;
        end
      end
      exp_ready <= w_load ? ((m_ready ? 0 : m_beat) == N) : m_ready;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    check("cyc o_valid", {31'b0, o_valid}, {31'b0, exp_valid});
    check("cyc o_ready", {31'b0, o_ready}, {31'b0, exp_ready});
    check("cyc o_drop",  {31'b0, o_drop},  {31'b0, exp_drop});
    check("cyc o_data",  {16'b0, o_data},  {16'b0, exp_data});
    check("cyc o_sat",   {31'b0, o_sat},   {31'b0, exp_sat});
    if (o_valid === 1'b1) vcount++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_w(input logic [7:0] v);
    for (int i = 0; i < N; i++) tb_w[i] = v;
  endtask

  task automatic load(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      w_load = 1'b1;
      w_data = 16'($urandom);
      if (b == N) w_data = tb_bias;
      else w_data[7:0] = tb_w[b];
      tick();
    end
    w_load = 1'b0;
  endtask

  task automatic set_win_const(input logic [7:0] v);
    for (int n = 0; n < N; n++) i_window[n*PIX_W +: PIX_W] = v;
  endtask

  task automatic set_win_idx();
    for (int n = 0; n < N; n++) i_window[n*PIX_W +: PIX_W] = 8'(n);
  endtask

  task automatic set_win_rand();
    for (int n = 0; n < N; n++) i_window[n*PIX_W +: PIX_W] = 8'($urandom);
  endtask

  task automatic send_one();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result after an accept edge and pin it to literals.
  task automatic wait_result(input string name, input logic [15:0] ed, input logic es);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (n < 8 && !got) begin
      tick();
      n++;
      if (o_valid === 1'b1) got = 1'b1;
    end
    check({name, " valid"}, {31'b0, got}, 32'd1);
    check({name, " latency"}, n, 32'd2);
    check({name, " data"}, {16'b0, o_data}, {16'b0, ed});
    check({name, " sat"}, {31'b0, o_sat}, {31'b0, es});
    check({name, " model"}, {16'b0, exp_data}, {16'b0, ed});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst_n = 1'b0; w_load = 1'b0; w_data = 16'h0; i_valid = 1'b0; i_window = '0;
    tb_bias = 16'h0;
    repeat (3) tick();
    check("rst o_valid", {31'b0, o_valid}, 32'd0);
    check("rst o_data",  {16'b0, o_data},  32'd0);
    check("rst o_sat",   {31'b0, o_sat},   32'd0);
    check("rst o_ready", {31'b0, o_ready}, 32'd0);
    check("rst o_drop",  {31'b0, o_drop},  32'd0);
    rst_n = 1'b1;

    // Window while EMPTY is dropped.
    set_win_const(8'd1);
    v0 = vcount;
    send_one();
    check("empty drop", {31'b0, o_drop}, 32'd1);
    tick();
    check("empty drop pulse", {31'b0, o_drop}, 32'd0);

    // Full load of ones: ready only after the bias beat.
    fill_w(8'd1); tb_bias = 16'd0;
    load(0, N - 1);
    check("ready before bias", {31'b0, o_ready}, 32'd0);
    load(N, N);
    check("ready after bias", {31'b0, o_ready}, 32'd1);
    check("empty no valid", vcount, v0);

    set_win_const(8'd1); send_one(); wait_result("ones", 16'd25, 1'b0);

    fill_w(8'd127); load(0, N);
    set_win_const(8'd255); send_one(); wait_result("sat_hi", 16'h7FFF, 1'b1);
    fill_w(8'h80); load(0, N);
    send_one(); wait_result("sat_lo", 16'h8000, 1'b1);

    fill_w(8'd1); tb_bias = 16'hFED4;
    load(0, N);
    set_win_idx(); send_one(); wait_result("idx_bias", 16'd0, 1'b0);

    // Four back-to-back windows give four consecutive results.
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_win_rand();
      tick();
      if (k >= 2) check("b2b valid", {31'b0, o_valid}, 32'd1);
    end
    i_valid = 1'b0;
    tick(); check("b2b valid", {31'b0, o_valid}, 32'd1);
    tick(); check("b2b valid", {31'b0, o_valid}, 32'd1);
    tick(); check("b2b end",   {31'b0, o_valid}, 32'd0);

    // Window during LOADING together with a beat: stored and dropped.
    fill_w(8'd2); tb_bias = 16'd10;
    v0 = vcount;
    load(0, 4);
    set_win_const(8'd1); i_valid = 1'b1;
    load(5, 5);
    i_valid = 1'b0;
    check("load drop", {31'b0, o_drop}, 32'd1);
    load(6, N);
    repeat (3) tick();
    check("load no valid", vcount, v0);

    // Reload from READY with a window on the same edge uses old weights.
    set_win_const(8'd1); i_valid = 1'b1;
    fill_w(8'd3); tb_bias = 16'd0;
    load(0, 0);
    i_valid = 1'b0;
    wait_result("old_wts", 16'd60, 1'b0);
    load(1, N);
    send_one(); wait_result("new_wts", 16'd75, 1'b0);

    // Reset with two windows in flight.
    set_win_rand(); i_valid = 1'b1; tick();
    set_win_rand(); tick();
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst o_valid", {31'b0, o_valid}, 32'd0);
    check("midrst o_data",  {16'b0, o_data},  32'd0);
    check("midrst o_ready", {31'b0, o_ready}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    v0 = vcount;
    repeat (6) tick();
    check("postrst no valid", vcount, v0);
    check("postrst not ready", {31'b0, o_ready}, 32'd0);

    // Randomized traffic with random weights and occasional reloads.
    for (int i = 0; i < N; i++) tb_w[i] = 8'($urandom);
    tb_bias = 16'($urandom);
    load(0, N);
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom % 4) != 0;
      set_win_rand();
      if (exp_ready) w_load = ($urandom % 32) == 0;
      else w_load = ($urandom % 4) != 0;
      w_data = 16'($urandom);
      tick();
    end
    i_valid = 1'b0; w_load = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
